// File: rtl/mealy_edge_detector_bank.sv
// CH-channel Mealy edge detector bank with per-channel rise/fall/both mode and saturating event counters.
// Optional macro MEALY_EDGE_STICKY_EN adds a STICKY output of per-channel event flags held until CLR.
module mealy_edge_detector_bank #(
   parameter int CH    = 4,
   parameter int CNT_W = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [CH-1:0]       IN,
   input  logic [2*CH-1:0]     MODE,
   input  logic                CLR,
   output logic [CH-1:0]       OUT,
   output logic [2*CH-1:0]     STATE,
   output logic                ANY,
`ifdef MEALY_EDGE_STICKY_EN
   output logic [CH-1:0]       STICKY,
`endif
   output logic [CH*CNT_W-1:0] CNT
);

   typedef enum logic [1:0] {
      S_INIT = 2'b00,
      S_LOW  = 2'b01,
      S_HIGH = 2'b10
   } state_e;

   state_e           state_q [CH];
   state_e           state_d [CH];
   logic [CNT_W-1:0] cnt_q   [CH];
   logic [CNT_W-1:0] cnt_d   [CH];
   logic [CH-1:0]    rise_c;
   logic [CH-1:0]    fall_c;
   logic [CH-1:0]    out_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         rise_c[i] = (state_q[i] == S_LOW) & IN[i];
         fall_c[i] = (state_q[i] == S_HIGH) & ~IN[i];
         out_c[i]  = (MODE[2*i] & rise_c[i]) | (MODE[2*i+1] & fall_c[i]);
         case (state_q[i])
            S_INIT, S_LOW, S_HIGH: state_d[i] = IN[i] ? S_HIGH : S_LOW;
            default:               state_d[i] = S_INIT;
         endcase
         // A clear that coincides with an event keeps that event as the first count.
         if (CLR)
            cnt_d[i] = {{(CNT_W-1){1'b0}}, out_c[i]};
         else if (out_c[i])
            cnt_d[i] = sat_inc(cnt_q[i]);
         else
            cnt_d[i] = cnt_q[i];
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < CH; i++) begin
         if (RST) begin
            state_q[i] <= S_INIT;
            cnt_q[i]   <= '0;
         end else begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

`ifdef MEALY_EDGE_STICKY_EN
   logic [CH-1:0] sticky_q;
   logic [CH-1:0] sticky_d;

   always_comb begin
      sticky_d = CLR ? out_c : (sticky_q | out_c);
   end

   always_ff @(posedge CLK) begin
      if (RST) sticky_q <= '0;
      else     sticky_q <= sticky_d;
   end

   assign STICKY = sticky_q;
`endif

   assign OUT = out_c;
   assign ANY = |out_c;

   for (genvar g = 0; g < CH; g++) begin : g_out
      assign STATE[2*g +: 2]         = state_q[g];
      assign CNT[g*CNT_W +: CNT_W]   = cnt_q[g];
   end

endmodule
